// File: rtl/mul16_shift_add.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier.
// One fulladd16 adds the multiplicand into the partial-product high word on each step.

module fulladd16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
endmodule

// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high; valid is held with stable data until that edge, ready never depends on valid.
module mul16_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c;

  assign add_b = lo[0] ? mcand : '0;

  fulladd16 u_add (
    .a     (hi),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  assign out_p = {hi, lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= in_a;
            lo       <= in_b;
            hi       <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Carry-out lands in hi[15], so the 32-bit product never overflows.
          {hi, lo} <= {add_c, add_s, lo[WIDTH-1:1]};
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
